qtable_best_hop_select: RTL

//  Read-side companion of the Q-table update block. On a start pulse it scans neighbor entries
//  0..neighborCount-1 through the shared neighbor memory banks (registered read, 1-cycle latency)
//  and returns the neighbor with the highest Q-value as next hop. Feeds the data-packet transmit path.

---
 rtl/qtable_best_hop_select_if.sv | 42 ++++
 rtl/qtable_best_hop_select.sv | 101 ++++++++++
 2 files changed

// File: rtl/qtable_best_hop_select_if.sv
// qtable_best_hop_select_if: start/table-read/result bundle between the hop selector and its controller
// Ports carried (directions given for the slave, i.e. the selector):
//   en             in   start pulse
//   neighborCount  in   number of valid table entries
//   mSourceID      in   neighbor ID read data
//   mSourceHops    in   neighbor hop-count read data
//   mClusterID     in   neighbor cluster-ID read data
//   mQValue        in   neighbor Q-value read data
//   rd_index       out  table read address
//   bestID         out  selected neighbor ID
//   bestHops       out  selected neighbor hops
//   bestClusterID  out  selected neighbor cluster ID
//   bestQValue     out  selected neighbor Q-value
//   found          out  a valid neighbor was selected
//   busy           out  scan in progress
//   done           out  one-cycle completion pulse
interface qtable_best_hop_select_if #(
    parameter int WORD_WIDTH = 16
);
    logic                  en;
    logic [WORD_WIDTH-1:0] neighborCount;
    logic [WORD_WIDTH-1:0] mSourceID;
    logic [WORD_WIDTH-1:0] mSourceHops;
    logic [WORD_WIDTH-1:0] mClusterID;
    logic [WORD_WIDTH-1:0] mQValue;
    logic [WORD_WIDTH-1:0] rd_index;
    logic [WORD_WIDTH-1:0] bestID;
    logic [WORD_WIDTH-1:0] bestHops;
    logic [WORD_WIDTH-1:0] bestClusterID;
    logic [WORD_WIDTH-1:0] bestQValue;
    logic                  found;
    logic                  busy;
    logic                  done;
    modport master (
        output en, neighborCount, mSourceID, mSourceHops, mClusterID, mQValue,
        input  rd_index, bestID, bestHops, bestClusterID, bestQValue, found, busy, done
    );
    modport slave (
        input  en, neighborCount, mSourceID, mSourceHops, mClusterID, mQValue,
        output rd_index, bestID, bestHops, bestClusterID, bestQValue, found, busy, done
    );
endinterface

// File: rtl/qtable_best_hop_select.sv
// qtable_best_hop_select: scans neighbor table entries and returns the highest-Q neighbor as next hop
// Ports:
//   clk   in  rising-edge clock
//   nrst  in  synchronous active-low reset
//   bus   slave modport of qtable_best_hop_select_if (start, table read port, result)
module qtable_best_hop_select #(
    parameter int WORD_WIDTH    = 16,
    parameter int MAX_NEIGHBORS = 32,
    parameter int READ_LATENCY  = 1
) (
    input logic                     clk,
    input logic                     nrst,
    qtable_best_hop_select_if.slave bus
);
    if (READ_LATENCY != 1) begin : g_bad_latency
        $error("qtable_best_hop_select supports READ_LATENCY=1 only");
    end
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SCAN  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;
    localparam logic [WORD_WIDTH-1:0] MAX_N = WORD_WIDTH'(MAX_NEIGHBORS);
    logic [1:0]            state_q, state_d;
    logic [WORD_WIDTH-1:0] n_q, n_d;
    logic [WORD_WIDTH-1:0] rd_index_q, rd_index_d;
    logic                  cmp_valid_q, cmp_valid_d;
    logic [WORD_WIDTH-1:0] best_id_q, best_id_d;
    logic [WORD_WIDTH-1:0] best_hops_q, best_hops_d;
    logic [WORD_WIDTH-1:0] best_clu_q, best_clu_d;
    logic [WORD_WIDTH-1:0] best_qv_q, best_qv_d;
    logic                  found_q, found_d;
    logic [WORD_WIDTH-1:0] n_clamped;
    logic [WORD_WIDTH-1:0] next_idx;
    logic                  take;
    assign n_clamped = bus.neighborCount > MAX_N ? MAX_N : bus.neighborCount;
    assign next_idx  = rd_index_q + 1'b1;
    // Read data is valid the cycle after an address was issued in SCAN; ID 0 marks an empty slot.
    assign take = cmp_valid_q && bus.mSourceID != '0 &&
                  (!found_q || bus.mQValue > best_qv_q ||
                   (bus.mQValue == best_qv_q && bus.mSourceHops < best_hops_q));
    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        rd_index_d  = rd_index_q;
        cmp_valid_d = state_q == SCAN;
        best_id_d   = take ? bus.mSourceID   : best_id_q;
        best_hops_d = take ? bus.mSourceHops : best_hops_q;
        best_clu_d  = take ? bus.mClusterID  : best_clu_q;
        best_qv_d   = take ? bus.mQValue     : best_qv_q;
        found_d     = take | found_q;
        case (state_q)
            IDLE: if (bus.en) begin
                n_d         = n_clamped;
                rd_index_d  = n_clamped == '0 ? rd_index_q : '0;
                state_d     = n_clamped == '0 ? DONE : SCAN;
                best_id_d   = '0;
                best_hops_d = '0;
                best_clu_d  = '0;
                best_qv_d   = '0;
                found_d     = 1'b0;
            end
            SCAN: begin
                state_d    = next_idx == n_q ? DRAIN : SCAN;
                rd_index_d = next_idx == n_q ? rd_index_q : next_idx;
            end
            DRAIN:   state_d = DONE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q     <= IDLE;
            n_q         <= '0;
            rd_index_q  <= '0;
            cmp_valid_q <= 1'b0;
            best_id_q   <= '0;
            best_hops_q <= '0;
            best_clu_q  <= '0;
            best_qv_q   <= '0;
            found_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            rd_index_q  <= rd_index_d;
            cmp_valid_q <= cmp_valid_d;
            best_id_q   <= best_id_d;
            best_hops_q <= best_hops_d;
            best_clu_q  <= best_clu_d;
            best_qv_q   <= best_qv_d;
            found_q     <= found_d;
        end
    end
    assign bus.rd_index      = rd_index_q;
    assign bus.bestID        = best_id_q;
    assign bus.bestHops      = best_hops_q;
    assign bus.bestClusterID = best_clu_q;
    assign bus.bestQValue    = best_qv_q;
    assign bus.found         = found_q;
    assign bus.busy          = state_q != IDLE;
    assign bus.done          = state_q == DONE;
endmodule
